// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame scheduling path.
//   sched_state_t           - scheduler FSM state encoding
//   GAP_CYCLES_DEFAULT      - latch gap after a frame (50 us at 48 MHz)
//   REFRESH_CYCLES_DEFAULT  - auto-resend interval, 0 = never
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  localparam int unsigned GAP_CYCLES_DEFAULT     = 2400;
  localparam int unsigned REFRESH_CYCLES_DEFAULT = 0;

endpackage

// File: rtl/frame_sched_if.sv
// Host command and frame-sender handshake bundle for frame_sched.
//   cmd_valid/cmd_length/cmd_ready    - host command slot handshake
//   send_trigger/send_length/send_done - frame sender start/length/idle level
// master: host + sender side; slave: the scheduler.
interface frame_sched_if #(
  parameter int addr_size = 8
) ();

  logic                 cmd_valid;
  logic [addr_size-1:0] cmd_length;
  logic                 cmd_ready;
  logic                 send_trigger;
  logic [addr_size-1:0] send_length;
  logic                 send_done;

  modport master (
    output cmd_valid, cmd_length, send_done,
    input  cmd_ready, send_trigger, send_length
  );

  modport slave (
    input  cmd_valid, cmd_length, send_done,
    output cmd_ready, send_trigger, send_length
  );

endinterface

// File: rtl/frame_sched_cycle_timer.sv
// Loadable down-counter with a zero flag.
//   clk, reset  - clock, synchronous active-high reset
//   load        - load load_value (wins over dec)
//   load_value  - value to load
//   dec         - decrement by one, saturating at zero
//   zero        - counter is zero
module cycle_timer #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/frame_sched.sv
// WS2812 frame scheduler: holds one pending host command, triggers the frame
// sender, enforces the latch gap after each frame and optionally resends the
// last frame after a period of idleness.
//   clk, reset  - clock, synchronous active-high reset
//   bus         - command slot and sender handshake (slave side)
//   busy        - high in every state except IDLE
//   frames_sent - number of triggered frames, wraps at 16 bits
//
// state | meaning
// IDLE  | waiting for a command in the slot (or for refresh to fill it)
// START | single cycle: send_trigger high
// BUSY  | sender is shifting pixels, waiting for send_done
// GAP   | latch gap running after a completed frame
module frame_sched
  import ws2812_pkg::*;
#(
  parameter int          addr_size      = 8,
  parameter int unsigned gap_cycles     = GAP_CYCLES_DEFAULT,
  parameter int unsigned refresh_cycles = REFRESH_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  frame_sched_if.slave        bus,
  output logic                busy,
  output logic [15:0]         frames_sent
);

  localparam logic [15:0] GAP_LOAD     = 16'(gap_cycles - 1);
  localparam bit          REFRESH_EN   = (refresh_cycles != 0);
  localparam logic [23:0] REFRESH_LAST = REFRESH_EN ? 24'(refresh_cycles - 1) : 24'd0;

  sched_state_t         state_q, state_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [addr_size-1:0] pend_length_q, pend_length_d;
  logic [addr_size-1:0] send_length_q, send_length_d;
  logic [15:0]          frames_sent_q, frames_sent_d;
  logic                 have_sent_q, have_sent_d;
  logic [23:0]          refresh_cnt_q, refresh_cnt_d;

  logic gap_load, gap_dec, gap_zero;
  logic cmd_accept, refresh_counting, refresh_fire;

  cycle_timer #(.width(16)) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .dec        (gap_dec),
    .zero       (gap_zero)
  );

  assign cmd_accept       = bus.cmd_valid && !pend_valid_q;
  // Refresh only idles on an empty slot, and only once there is a frame to repeat.
  assign refresh_counting = REFRESH_EN && (state_q == IDLE) && !pend_valid_q && have_sent_q;
  // A host command on the expiry edge wins; the refresh is simply dropped.
  assign refresh_fire     = refresh_counting && (refresh_cnt_q == REFRESH_LAST) && !cmd_accept;

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_length_d = pend_length_q;
    send_length_d = send_length_q;
    frames_sent_d = frames_sent_q;
    have_sent_d   = have_sent_q;
    refresh_cnt_d = refresh_cnt_q;
    gap_load      = 1'b0;
    gap_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          state_d       = START;
          send_length_d = pend_length_q;
        end
      end
      START: begin
        state_d       = BUSY;
        frames_sent_d = frames_sent_q + 16'd1;
        have_sent_d   = 1'b1;
      end
      BUSY: begin
        if (bus.send_done) begin
          state_d  = GAP;
          gap_load = 1'b1;
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Slot: draining into START takes priority; it is only possible when the
    // slot is full, in which case no host command can be accepted anyway.
    if ((state_q == IDLE) && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end else if (cmd_accept) begin
      pend_valid_d  = 1'b1;
      pend_length_d = bus.cmd_length;
    end else if (refresh_fire) begin
      pend_valid_d  = 1'b1;
      pend_length_d = send_length_q;
    end

    if (!refresh_counting || cmd_accept || refresh_fire) begin
      refresh_cnt_d = 24'd0;
    end else begin
      refresh_cnt_d = refresh_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_valid_q  <= 1'b0;
      pend_length_q <= '0;
      send_length_q <= '0;
      frames_sent_q <= 16'd0;
      have_sent_q   <= 1'b0;
      refresh_cnt_q <= 24'd0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_length_q <= pend_length_d;
      send_length_q <= send_length_d;
      frames_sent_q <= frames_sent_d;
      have_sent_q   <= have_sent_d;
      refresh_cnt_q <= refresh_cnt_d;
    end
  end

  assign bus.cmd_ready    = !pend_valid_q;
  assign bus.send_trigger = (state_q == START);
  assign bus.send_length  = send_length_q;
  assign busy             = (state_q != IDLE);
  assign frames_sent      = frames_sent_q;

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: dut_a uses the default gap, dut_b a short gap with
// refresh enabled. Directed vectors, hand sequences and a randomized run
// against a cycle-level reference model of the scheduling rules.
module tb_frame_sched;

  localparam int AW    = 8;
  localparam int GAP_A = 2400;
  localparam int GAP_B = 3;
  localparam int REF_B = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_a, reset_b;
  logic        busy_a, busy_b;
  logic [15:0] frames_a, frames_b;

  frame_sched_if #(.addr_size(AW)) bus_a ();
  frame_sched_if #(.addr_size(AW)) bus_b ();

  frame_sched #(.addr_size(AW)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.slave), .busy(busy_a), .frames_sent(frames_a)
  );

  frame_sched #(.addr_size(AW), .gap_cycles(GAP_B), .refresh_cycles(REF_B)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.slave), .busy(busy_b), .frames_sent(frames_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_trig(input bit sel_b, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((sel_b ? bus_b.send_trigger : bus_a.send_trigger) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_trigger", {31'd0, seen}, 32'd1);
  endtask

  typedef struct packed {
    logic        cv;
    logic [7:0]  cl;
    logic        sd;
    logic        ready;
    logic        trig;
    logic        busy;
    logic [7:0]  len;
    logic [15:0] frames;
  } vec_t;

  vec_t tbl [23];

  // reference model state (dut_b)
  bit          m_full, m_trig, m_in_frame, m_sent;
  logic [7:0]  m_slen, m_len;
  logic [15:0] m_frames;
  int          m_gap_left, m_idle_run;

  task automatic model_reset();
    m_full = 0; m_trig = 0; m_in_frame = 0; m_sent = 0;
    m_slen = 0; m_len = 0; m_frames = 0; m_gap_left = 0; m_idle_run = 0;
  endtask

  function automatic bit model_busy();
    return m_trig || m_in_frame || (m_gap_left > 0);
  endfunction

  task automatic model_step(input bit cv, input logic [7:0] cl, input bit sd);
    bit idle, acc, full_before, n_trig, n_in, refresh_load;
    int n_gap;
    idle = !model_busy();
    full_before = m_full;
    acc = cv && !m_full;
    n_trig = 0; n_in = m_in_frame; n_gap = m_gap_left; refresh_load = 0;
    if (idle && m_full) begin
      n_trig = 1; m_len = m_slen; m_full = 0;
    end
    if (m_trig) begin
      n_in = 1; m_frames = m_frames + 16'd1; m_sent = 1;
    end
    if (m_in_frame && sd) begin
      n_in = 0; n_gap = GAP_B;
    end else if (m_gap_left > 0) begin
      n_gap = m_gap_left - 1;
    end
    if (idle && !full_before && m_sent && REF_B > 0) begin
      if (acc) m_idle_run = 0;
      else begin
        m_idle_run++;
        if (m_idle_run == REF_B) begin
          refresh_load = 1; m_idle_run = 0;
        end
      end
    end else begin
      m_idle_run = 0;
    end
    if (acc) begin
      m_full = 1; m_slen = cl;
    end else if (refresh_load) begin
      m_full = 1; m_slen = m_len;
    end
    m_trig = n_trig; m_in_frame = n_in; m_gap_left = n_gap;
  endtask

  initial begin
    bit seen;
    int t0, t1, t_done, cnt, idle_cnt, ntrig;
    bit bad;
    logic [7:0] last_len;
    int pct_tbl [8] = '{80, 3, 40, 0, 10, 100, 0, 20};
    bit snd_arm;
    int snd_left;
    bit cv;
    logic [7:0] cl;

    tbl[0]  = '{1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[2]  = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'd7, 16'd0};
    tbl[3]  = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 16'd1};
    tbl[4]  = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 16'd1};
    tbl[5]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 16'd1};
    tbl[6]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 16'd1};
    tbl[7]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 16'd1};
    tbl[8]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 16'd1};
    tbl[9]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7, 16'd1};
    tbl[10] = '{1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 16'd1};
    tbl[11] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 16'd2};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 16'd2};
    tbl[13] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 16'd2};
    tbl[14] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 16'd2};
    tbl[15] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 16'd2};
    tbl[16] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 16'd2};
    tbl[17] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 16'd2};
    tbl[18] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 16'd3};
    tbl[19] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 16'd3};
    tbl[20] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 16'd3};
    tbl[21] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 16'd3};
    tbl[22] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 16'd3};

    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_length = '0; bus_a.send_done = 1'b1;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_length = '0; bus_b.send_done = 1'b1;
    repeat (3) @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;

    // ---------------- dut_b: no refresh before any frame ----------------
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      if (busy_b !== 1'b0 || bus_b.send_trigger !== 1'b0) bad = 1;
      @(negedge clk);
    end
    chk("no_refresh_before_first_frame", {31'd0, bad}, 32'd0);

    // ---------------- dut_b: vector table ----------------
    for (int i = 0; i < 23; i++) begin
      bus_b.cmd_valid  = tbl[i].cv;
      bus_b.cmd_length = tbl[i].cl;
      bus_b.send_done  = tbl[i].sd;
      chk($sformatf("vec%0d_ready", i),  {31'd0, bus_b.cmd_ready},    {31'd0, tbl[i].ready});
      chk($sformatf("vec%0d_trig", i),   {31'd0, bus_b.send_trigger}, {31'd0, tbl[i].trig});
      chk($sformatf("vec%0d_busy", i),   {31'd0, busy_b},             {31'd0, tbl[i].busy});
      chk($sformatf("vec%0d_len", i),    {24'd0, bus_b.send_length},  {24'd0, tbl[i].len});
      chk($sformatf("vec%0d_frames", i), {16'd0, frames_b},           {16'd0, tbl[i].frames});
      @(negedge clk);
    end

    // ---------------- dut_b: refresh after REF_B idle cycles ----------------
    bus_b.cmd_valid = 1'b0; bus_b.send_done = 1'b1;
    idle_cnt = 1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus_b.send_trigger === 1'b1) begin seen = 1; break; end
      if (busy_b === 1'b0) idle_cnt++;
      @(negedge clk);
    end
    chk("refresh_seen", {31'd0, seen}, 32'd1);
    chk("refresh_idle_cycles", idle_cnt, REF_B + 1);
    chk("refresh_len", {24'd0, bus_b.send_length}, 32'd5);

    // ---------------- dut_b: host command on the refresh-expiry edge ----------------
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_b === 1'b0) break;
    end
    chk("refresh_frame_done", {31'd0, busy_b}, 32'd0);
    repeat (REF_B - 1) @(negedge clk);
    bus_b.cmd_valid = 1'b1; bus_b.cmd_length = 8'd42;
    chk("collide_ready", {31'd0, bus_b.cmd_ready}, 32'd1);
    @(negedge clk);
    bus_b.cmd_valid = 1'b0;
    ntrig = 0; last_len = 8'd0;
    for (int i = 0; i < 60; i++) begin
      if (bus_b.send_trigger === 1'b1) begin ntrig++; last_len = bus_b.send_length; end
      @(negedge clk);
    end
    chk("collide_trigger_count", ntrig, 1);
    chk("collide_len", {24'd0, last_len}, 32'd42);

    // ---------------- dut_b: frames_sent wrap ----------------
    force dut_b.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut_b.frames_sent_q;
    bus_b.cmd_valid = 1'b1; bus_b.cmd_length = 8'd9;
    @(negedge clk);
    bus_b.cmd_valid = 1'b0;
    wait_trig(1'b1, 10, seen);
    chk("wrap_len", {24'd0, bus_b.send_length}, 32'd9);
    @(negedge clk);
    chk("wrap_frames", {16'd0, frames_b}, 32'd0);

    // ---------------- dut_a: basic latency and gap length ----------------
    reset_a = 1'b1;
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    chk("a_ready_after_reset", {31'd0, bus_a.cmd_ready}, 32'd1);
    chk("a_frames_reset", {16'd0, frames_a}, 32'd0);
    bus_a.cmd_valid = 1'b1; bus_a.cmd_length = 8'd7;
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    chk("a_trig_too_early", {31'd0, bus_a.send_trigger}, 32'd0);
    chk("a_ready_slot_full", {31'd0, bus_a.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("a_trig_latency", {31'd0, bus_a.send_trigger}, 32'd1);
    chk("a_len7", {24'd0, bus_a.send_length}, 32'd7);
    @(negedge clk);
    chk("a_trig_one_cycle", {31'd0, bus_a.send_trigger}, 32'd0);
    chk("a_frames1", {16'd0, frames_a}, 32'd1);
    bus_a.send_done = 1'b0;
    repeat (8) @(negedge clk);
    bus_a.send_done = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    chk("a_gap_cycles", cnt, GAP_A);

    // ---------------- dut_a: commands 3 and 5 during a frame ----------------
    bus_a.cmd_valid = 1'b1; bus_a.cmd_length = 8'd1;
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    wait_trig(1'b0, 10, seen);
    t0 = cyc;
    @(negedge clk);
    bus_a.send_done = 1'b0;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_length = 8'd3;
    chk("a_cmd3_ready", {31'd0, bus_a.cmd_ready}, 32'd1);
    @(negedge clk);
    bus_a.cmd_length = 8'd5;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus_a.cmd_ready !== 1'b0) bad = 1;
      @(negedge clk);
    end
    bus_a.send_done = 1'b1;
    t_done = cyc;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus_a.send_trigger === 1'b1) begin seen = 1; break; end
      if (bus_a.cmd_ready !== 1'b0) bad = 1;
    end
    t1 = cyc;
    chk("a_trig3_seen", {31'd0, seen}, 32'd1);
    chk("a_cmd5_stalled", {31'd0, bad}, 32'd0);
    chk("a_len3", {24'd0, bus_a.send_length}, 32'd3);
    chk("a_spacing_ok", {31'd0, (t1 - t0) >= (t_done - t0) + GAP_A + 1}, 32'd1);
    chk("a_cmd5_ready", {31'd0, bus_a.cmd_ready}, 32'd1);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    @(negedge clk);
    wait_trig(1'b0, 3000, seen);
    chk("a_len5", {24'd0, bus_a.send_length}, 32'd5);

    // ---------------- dut_a: reset during BUSY with slot full ----------------
    @(negedge clk);
    bus_a.send_done = 1'b0;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_length = 8'd9;
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    chk("a_pre_reset_busy", {31'd0, busy_a}, 32'd1);
    chk("a_pre_reset_full", {31'd0, bus_a.cmd_ready}, 32'd0);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    bus_a.send_done = 1'b1;
    chk("a_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("a_rst_trig", {31'd0, bus_a.send_trigger}, 32'd0);
    chk("a_rst_ready", {31'd0, bus_a.cmd_ready}, 32'd1);
    chk("a_rst_frames", {16'd0, frames_a}, 32'd0);
    chk("a_rst_len", {24'd0, bus_a.send_length}, 32'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_a.send_trigger !== 1'b0 || busy_a !== 1'b0) bad = 1;
    end
    chk("a_rst_pending_lost", {31'd0, bad}, 32'd0);

    // ---------------- dut_b: randomized run against the model ----------------
    bus_b.cmd_valid = 1'b0; bus_b.send_done = 1'b1;
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    model_reset();
    snd_arm = 0; snd_left = 0;
    for (int i = 0; i < 4000; i++) begin
      chk("rnd_ready",  {31'd0, bus_b.cmd_ready},    {31'd0, !m_full});
      chk("rnd_trig",   {31'd0, bus_b.send_trigger}, {31'd0, m_trig});
      chk("rnd_busy",   {31'd0, busy_b},             {31'd0, model_busy()});
      chk("rnd_len",    {24'd0, bus_b.send_length},  {24'd0, m_len});
      chk("rnd_frames", {16'd0, frames_b},           {16'd0, m_frames});
      cv = ($urandom_range(0, 99) < pct_tbl[i / 500]);
      cl = 8'($urandom_range(0, 255));
      bus_b.cmd_valid = cv;
      bus_b.cmd_length = cl;
      if (snd_arm) begin
        bus_b.send_done = 1'b0;
        snd_left = int'(m_len % 8) + 1 + int'($urandom_range(0, 3));
        snd_arm = 0;
      end else if (snd_left > 0) begin
        snd_left--;
        if (snd_left == 0) bus_b.send_done = 1'b1;
      end
      if (m_trig) snd_arm = 1;
      model_step(cv, cl, bus_b.send_done);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
